// File: rtl/switch_config_loader.sv
// Serial configuration loader: hunts SYNC, shifts 18 routing entries into a shadow register,
// validates them and commits the whole set to cfg_bus. Optional XOR trailer under CFG_CHECKSUM_EN.
module switch_config_loader #(
    parameter int unsigned N_TB    = 5,
    parameter int unsigned N_LR    = 4,
    parameter int unsigned ENTRY_W = 6,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_valid,
    input  logic                                    cfg_data,
    output logic                                    cfg_ready,
    input  logic                                    cfg_clr,
    output logic [ENTRY_W*(2*N_TB+2*N_LR)-1:0]      cfg_bus,
    output logic                                    cfg_commit,
    output logic [1:0]                              cfg_err
);
    localparam int unsigned NumEnt  = 2 * N_TB + 2 * N_LR;
    localparam int unsigned BusW    = ENTRY_W * NumEnt;
    localparam logic [6:0]  LastBit = 7'(BusW - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StCommit, StError} state_e;

    state_e               state;
    logic [7:0]           window;
    logic [ENTRY_W-1:0]   field;
    logic [2:0]           phase;
    logic [6:0]           bit_cnt;
    logic [BusW-1:0]      shadow;
    logic [BusW-1:0]      bus_q;
    logic                 commit_q;
    logic [1:0]           err_q;
    logic                 ready_q;
`ifdef CFG_CHECKSUM_EN
    logic [ENTRY_W-1:0]   csum;
`endif

    logic                 accept;
    logic [7:0]           win_next;
    logic [ENTRY_W-1:0]   field_next;

    assign accept     = cfg_valid && ready_q;
    assign win_next   = {window[6:0], cfg_data};
    assign field_next = {field[ENTRY_W-2:0], cfg_data};

    // [5:3] wire index, [2:0] source side
    function automatic logic entry_legal(input logic [5:0] e);
        case (e[2:0])
            3'd0:       return 1'b1;
            3'd1, 3'd3: return int'(e[5:3]) < int'(N_TB);
            3'd2, 3'd4: return int'(e[5:3]) < int'(N_LR);
            default:    return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            window   <= '0;
            field    <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            shadow   <= '0;
            bus_q    <= '0;
            commit_q <= 1'b0;
            err_q    <= 2'b00;
            ready_q  <= 1'b1;
`ifdef CFG_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            commit_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        window <= win_next;
                        if (win_next == SYNC) begin
                            state   <= StLoad;
                            bit_cnt <= '0;
                            phase   <= '0;
`ifdef CFG_CHECKSUM_EN
                            csum    <= '0;
`endif
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        field   <= field_next;
                        bit_cnt <= bit_cnt + 7'd1;
                        if (phase == 3'd5) begin
                            phase  <= '0;
                            // first entry received ends up in the lowest slot (top0)
                            shadow <= {field_next, shadow[BusW-1:ENTRY_W]};
`ifdef CFG_CHECKSUM_EN
                            csum   <= csum ^ field_next;
`endif
                            if (!entry_legal(field_next)) begin
                                state   <= StError;
                                err_q   <= 2'b01;
                                ready_q <= 1'b0;
                            end else if (bit_cnt == LastBit) begin
`ifdef CFG_CHECKSUM_EN
                                state   <= StCheck;
`else
                                state   <= StCommit;
                                ready_q <= 1'b0;
`endif
                            end
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                end
`ifdef CFG_CHECKSUM_EN
                StCheck: begin
                    if (accept) begin
                        field <= field_next;
                        if (phase == 3'd5) begin
                            phase   <= '0;
                            ready_q <= 1'b0;
                            if (field_next == csum) begin
                                state <= StCommit;
                            end else begin
                                state <= StError;
                                err_q <= 2'b10;
                            end
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                end
`endif
                StCommit: begin
                    bus_q    <= shadow;
                    commit_q <= 1'b1;
                    err_q    <= 2'b00;
                    window   <= '0;
                    state    <= StIdle;
                    ready_q  <= 1'b1;
                end
                StError: begin
                    if (cfg_clr) begin
                        window  <= '0;
                        state   <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready  = ready_q;
    assign cfg_bus    = bus_q;
    assign cfg_commit = commit_q;
    assign cfg_err    = err_q;

endmodule
